// File: rtl/array_14_ctrl_pkg.sv
// Shared constants and types for the two-requester array controller.
package array_14_ctrl_pkg;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 24;
    localparam int unsigned DATA_W = LANES * LANE_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // One requester's access as presented on the request channel
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LANES-1:0]  wmask;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/array_14_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves
// to the port not served after every grant.
module rr_arb2
    import array_14_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    port_e      ptr_q, ptr_d;
    logic [1:0] grant_c;

    always_comb begin
        grant_c = 2'b00;
        ptr_d   = ptr_q;
        if (en_i) begin
            if (valid_i[0] && (!valid_i[1] || ptr_q == PORT_A)) begin
                grant_c = 2'b01;
            end else if (valid_i[1]) begin
                grant_c = 2'b10;
            end
        end
        if (grant_c[0]) begin
            ptr_d = PORT_B;
        end else if (grant_c[1]) begin
            ptr_d = PORT_A;
        end
    end

    assign grant_o = grant_c;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= PORT_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/array_14_ctrl.sv
// Owns the array macro's RW port: zero sweep after reset/clear, then
// round-robin service of requesters A and B with tagged read responses.
module array_14_ctrl
    import array_14_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              init_done,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_write,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [LANES-1:0]  a_req_wmask,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_resp_valid,
    output logic [DATA_W-1:0] a_resp_data,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_write,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [LANES-1:0]  b_req_wmask,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_resp_valid,
    output logic [DATA_W-1:0] b_resp_data,

    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]  mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_q, rd_d;
    port_e             tag_q, tag_d;

    req_t       a_req, b_req, sel_req;
    logic [1:0] grant;
    logic       arb_en;

    assign a_req = '{write: a_req_write, addr: a_req_addr,
                     wmask: a_req_wmask, wdata: a_req_wdata};
    assign b_req = '{write: b_req_write, addr: b_req_addr,
                     wmask: b_req_wmask, wdata: b_req_wdata};

    // A clear request suppresses any grant in the cycle it arrives
    assign arb_en = (state_q == RUN) && !clear_req;

    rr_arb2 u_arb (
        .clk_i   (clock),
        .rst_n_i (reset_n),
        .en_i    (arb_en),
        .valid_i ({b_req_valid, a_req_valid}),
        .grant_o (grant)
    );

    assign sel_req     = grant[1] ? b_req : a_req;
    assign a_req_ready = grant[0];
    assign b_req_ready = grant[1];
    assign init_done   = (state_q == RUN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = 1'b0;
        tag_d     = tag_q;
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        case (state_q)
            INIT: begin
                mem_en    = 1'b1;
                mem_wmode = 1'b1;
                mem_addr  = cnt_q;
                mem_wmask = '1;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else if (|grant) begin
                    mem_en    = 1'b1;
                    mem_wmode = sel_req.write;
                    mem_addr  = sel_req.addr;
                    mem_wmask = sel_req.wmask;
                    mem_wdata = sel_req.wdata;
                    rd_d      = !sel_req.write;
                    tag_d     = grant[1] ? PORT_B : PORT_A;
                end
            end
            default: state_d = INIT;
        endcase
        // Keep the macro idle while reset is held, even though INIT is active
        if (!reset_n) begin
            mem_en    = 1'b0;
            mem_wmode = 1'b0;
            mem_addr  = '0;
            mem_wmask = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            tag_q   <= PORT_A;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            tag_q   <= tag_d;
        end
    end

    assign a_resp_valid = rd_q && (tag_q == PORT_A);
    assign b_resp_valid = rd_q && (tag_q == PORT_B);
    assign a_resp_data  = a_resp_valid ? mem_rdata : '0;
    assign b_resp_data  = b_resp_valid ? mem_rdata : '0;

endmodule
